uart_tx_buffer: RTL

Byte FIFO with a transmit-pacing state machine that sits between the UART control stage and the UART transmitter.
- Absorbs one-cycle write strobes (wrsig/datain) from the control stage.
- Replays stored bytes to the transmitter one at a time, each only after the transmitter reports idle.
- Runs on the 16×baud clock from the clock divider.
- Removes byte loss when the producer writes faster than the line rate.

---
 rtl/uart_tx_buffer_pkg.sv | 19 +
 rtl/uart_fifo_mem.sv | 28 ++
 rtl/uart_tx_buffer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_tx_buffer_pkg.sv
// Shared types and defaults for the UART transmit buffer.
// Holds the pacing FSM state encoding, byte width and default sizing.
// No logic; imported by the buffer top and its storage sub-module.
package uart_tx_buffer_pkg;

  localparam int BYTE_W           = 8;
  localparam int DEF_DEPTH        = 16;
  localparam int DEF_ADDR_W       = 4;
  localparam int DEF_BUSY_TIMEOUT = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_STROBE    = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the transmit buffer: synchronous write, registered read.
// Latency: rd_dat reflects mem[rd_addr] one clock after the address is applied.
// No flow control here; the parent owns pointers, count and accept/drop decisions.
module uart_fifo_mem
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BYTE_W-1:0] wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BYTE_W-1:0] rd_dat
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // Storage needs no reset: the parent's count defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
    rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus pacing FSM feeding a UART transmitter one byte per frame.
// Latency: write at edge N into an empty buffer -> tx_data after N+2, tx_wrsig pulse after N+3.
// Writes beyond DEPTH are dropped (sticky overflow) unless a pop lands on the same edge.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrsig,
  input  logic [BYTE_W-1:0] datain,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_wrsig,
  input  logic              tx_idle,
  output logic              tx_timeout
);

  localparam int               TMR_W     = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(BUSY_TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [TMR_W-1:0]  timer;
  logic [BYTE_W-1:0] rd_dat;
  logic              pop;
  logic              push;
  logic [ADDR_W:0]   count_nxt;

  // S_LOAD is only entered with count != 0, so a pop can never underflow.
  assign pop  = (state == S_LOAD);
  // A full buffer still accepts a byte when the same edge frees a slot.
  assign push = wrsig && ((count != DEPTH_CNT) || pop);

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + (ADDR_W + 1)'(1);
    end else if (!push && pop) begin
      count_nxt = count - (ADDR_W + 1)'(1);
    end
  end

  // Pointer, occupancy and overflow bookkeeping; full is registered from the next count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + ADDR_W'(1);
      end
      if (wrsig && !push) begin
        overflow <= 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wptr),
    .wr_dat  (datain),
    .rd_addr (rptr),
    .rd_dat  (rd_dat)
  );

  // Pacing FSM: load a byte, strobe once, then wait for the transmitter to go busy and idle again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tx_data    <= '0;
      tx_wrsig   <= 1'b0;
      tx_timeout <= 1'b0;
      timer      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((count != '0) && tx_idle) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // rd_dat already holds mem[rptr]: rptr has been stable since the previous pop.
          tx_data <= rd_dat;
          state   <= S_STROBE;
        end
        S_STROBE: begin
          tx_wrsig <= 1'b1;
          timer    <= '0;
          state    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          tx_wrsig <= 1'b0;
          if (!tx_idle) begin
            state <= S_WAIT_DONE;
          end else if (timer == TMR_LAST) begin
            // Transmitter never acknowledged; treat the byte as sent so the queue keeps draining.
            tx_timeout <= 1'b1;
            state      <= S_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (tx_idle) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
